// File: rtl/fp_result_pack.sv
// fp_result_pack: FPU result packing stage with special-case substitution,
// exception flags and a 2-entry valid/ready skid buffer.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is registered)
//   in_sign/man/exp     normalised result fields
//   in_shift            subnormal right-shift amount
//   in_ovf/unf/inv      exception conditions (priority ovf > unf > inv)
//   out_valid/out_ready output handshake
//   out_result          {sign, exp, fraction}
//   out_flags           {inv, ovf, unf, inexact} of out_result
//   sticky_flags        flags accumulated on output transfer
//   sticky_clr          clear sticky_flags
module fp_result_pack #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 23,
   parameter int SHIFT_W = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [MAN_W-1:0]         in_man,
   input  logic [EXP_W-1:0]         in_exp,
   input  logic [SHIFT_W-1:0]       in_shift,
   input  logic                     in_ovf,
   input  logic                     in_unf,
   input  logic                     in_inv,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_result,
   output logic [3:0]               out_flags,
   output logic [3:0]               sticky_flags,
   input  logic                     sticky_clr
);
   localparam int BEAT_W = EXP_W + MAN_W + 5;
   logic [MAN_W-1:0]  lost_mask;
   logic [BEAT_W-1:0] beat, out_q, out_d, skid_q, skid_d;
   logic              out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic              in_ready_q, in_ready_d;
   logic [3:0]        sticky_q, sticky_d;
   logic              accept, xfer, out_free;
   // A shift of MAN_W or more yields an all-ones mask and a zero fraction,
   // so every mantissa bit counts towards inexact in that case.
   always_comb begin
      lost_mask = ~({MAN_W{1'b1}} << in_shift);
      beat = in_ovf ? {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 4'b0101}
           : in_unf ? {in_sign, {EXP_W{1'b0}}, in_man >> in_shift, 3'b001, |(in_man & lost_mask)}
           : in_inv ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}, 4'b1000}
           : {in_sign, in_exp, in_man, 4'b0000};
   end
   // OUT is free when empty or draining; SKID always refills OUT first so
   // beats leave in acceptance order. Accept only happens with SKID empty.
   always_comb begin
      accept     = in_valid && in_ready_q;
      xfer       = out_vld_q && out_ready;
      out_free   = !out_vld_q || out_ready;
      out_vld_d  = out_free ? (skid_vld_q || accept) : 1'b1;
      out_d      = !out_free ? out_q : skid_vld_q ? skid_q : accept ? beat : out_q;
      skid_vld_d = !out_free && (skid_vld_q || accept);
      skid_d     = (!out_free && accept) ? beat : skid_q;
      in_ready_d = !skid_vld_d;
      sticky_d   = (sticky_clr ? 4'b0000 : sticky_q) | (xfer ? out_q[3:0] : 4'b0000);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b0;
         sticky_q   <= 4'b0000;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
         sticky_q   <= sticky_d;
      end
   end
   assign in_ready     = in_ready_q;
   assign out_valid    = out_vld_q;
   assign out_result   = out_q[BEAT_W-1:4];
   assign out_flags    = out_q[3:0];
   assign sticky_flags = sticky_q;
endmodule
